// File: rtl/wieg_regelaar.sv
// wieg_regelaar: closed-loop cradle rocking controller.
// Steps the motor intensity up while the stress evaluator reports rising stress,
// down while it reports falling stress, winds the motor down once level 0 calms
// the baby, and latches an alarm when stress keeps rising at maximum intensity.
// One verdict is taken per evaluation window of WACHT slow ticks.
module wieg_regelaar #(
    parameter int NIVEAUS      = 8,
    parameter int START_NIVEAU = 2,
    parameter int WACHT        = 16,
    parameter int MAX_POGINGEN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       slow,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       gedaald,
    input  logic                       gelijk,
    output logic [$clog2(NIVEAUS)-1:0] niveau,
    output logic                       motor_aan,
    output logic                       venster_einde,
    output logic                       alarm,
    output logic [2:0]                 toestand
);

    localparam int NW = $clog2(NIVEAUS);
    localparam int TW = $clog2(WACHT);
    localparam int PW = $clog2(MAX_POGINGEN + 1);

    localparam logic [NW-1:0] NIVEAU_MAX    = NW'(NIVEAUS - 1);
    localparam logic [NW-1:0] NIVEAU_START  = NW'(START_NIVEAU);
    localparam logic [TW-1:0] TELLER_LAATST = TW'(WACHT - 1);
    localparam logic [PW-1:0] POGING_LAATST = PW'(MAX_POGINGEN - 1);

    typedef enum logic [2:0] {
        RUST     = 3'd0,
        WIEGEN   = 3'd1,
        EVALUEER = 3'd2,
        AFBOUW   = 3'd3,
        ALARM    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] niveau_q, niveau_d;
    logic [TW-1:0] teller_q, teller_d;
    logic [PW-1:0] poging_q, poging_d;
    logic          motor_aan_q, motor_aan_d;
    logic          venster_einde_q, venster_einde_d;
    logic          alarm_q, alarm_d;

    // Window is complete on the slow tick that finds the counter at its last value.
    logic venster_vol;
    assign venster_vol = slow && (teller_q == TELLER_LAATST);

    // State and output registers; reset acts immediately, also mid-session.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= RUST;
            niveau_q        <= '0;
            teller_q        <= '0;
            poging_q        <= '0;
            motor_aan_q     <= 1'b0;
            venster_einde_q <= 1'b0;
            alarm_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            niveau_q        <= niveau_d;
            teller_q        <= teller_d;
            poging_q        <= poging_d;
            motor_aan_q     <= motor_aan_d;
            venster_einde_q <= venster_einde_d;
            alarm_q         <= alarm_d;
        end
    end

    // Next-state, level and counter decisions; stop overrides everything.
    always_comb begin
        state_d  = state_q;
        niveau_d = niveau_q;
        teller_d = teller_q;
        poging_d = poging_q;

        if (stop) begin
            state_d  = RUST;
            niveau_d = '0;
            teller_d = '0;
            poging_d = '0;
        end else begin
            case (state_q)
                RUST: begin
                    niveau_d = '0;
                    teller_d = '0;
                    poging_d = '0;
                    if (start) begin
                        state_d  = WIEGEN;
                        niveau_d = NIVEAU_START;
                    end
                end

                WIEGEN: begin
                    if (venster_vol) begin
                        state_d  = EVALUEER;
                        teller_d = '0;
                    end else if (slow) begin
                        teller_d = teller_q + TW'(1);
                    end
                end

                EVALUEER: begin
                    state_d = WIEGEN;
                    if (gedaald) begin
                        // Calmer: step down, or wind down once already at the lowest level.
                        if (niveau_q != '0) begin
                            niveau_d = niveau_q - NW'(1);
                            poging_d = '0;
                        end else begin
                            state_d  = AFBOUW;
                            teller_d = '0;
                        end
                    end else if (gelijk) begin
                        // Unchanged stress: keep level and attempt count as they are.
                        state_d = WIEGEN;
                    end else if (niveau_q != NIVEAU_MAX) begin
                        niveau_d = niveau_q + NW'(1);
                        poging_d = '0;
                    end else if (poging_q == POGING_LAATST) begin
                        // Still rising at full intensity after the allowed attempts.
                        state_d  = ALARM;
                        niveau_d = '0;
                    end else begin
                        poging_d = poging_q + PW'(1);
                    end
                end

                AFBOUW: begin
                    niveau_d = '0;
                    if (venster_vol) begin
                        state_d  = RUST;
                        teller_d = '0;
                    end else if (slow) begin
                        teller_d = teller_q + TW'(1);
                    end
                end

                ALARM: begin
                    niveau_d = '0;
                end

                default: begin
                    state_d  = RUST;
                    niveau_d = '0;
                    teller_d = '0;
                    poging_d = '0;
                end
            endcase
        end
    end

    // Registered outputs follow the state being entered, so they change together with it.
    always_comb begin
        motor_aan_d     = (state_d == WIEGEN) || (state_d == EVALUEER) || (state_d == AFBOUW);
        venster_einde_d = (state_d == EVALUEER);
        alarm_d         = (state_d == ALARM);
    end

    assign niveau        = niveau_q;
    assign motor_aan     = motor_aan_q;
    assign venster_einde = venster_einde_q;
    assign alarm         = alarm_q;
    assign toestand      = state_q;

endmodule

// File: tb/tb_wieg_regelaar.sv
// Testbench for wieg_regelaar: directed verdict sequences, scoreboard checked
// after every evaluation window, plus direct checks of reset, stop and wind-down.
module tb_wieg_regelaar;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       slow = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       gedaald = 1'b0;
    logic       gelijk = 1'b0;
    logic [2:0] niveau;
    logic       motor_aan;
    logic       venster_einde;
    logic       alarm;
    logic [2:0] toestand;

    typedef struct packed {
        logic [2:0] niv;
        logic [2:0] st;
        logic       mot;
        logic       alm;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;

    wieg_regelaar #(
        .NIVEAUS(8),
        .START_NIVEAU(2),
        .WACHT(4),
        .MAX_POGINGEN(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .slow(slow),
        .start(start),
        .stop(stop),
        .gedaald(gedaald),
        .gelijk(gelijk),
        .niveau(niveau),
        .motor_aan(motor_aan),
        .venster_einde(venster_einde),
        .alarm(alarm),
        .toestand(toestand)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // slow tick: one clock high out of every five
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            c = (c == 4) ? 0 : c + 1;
            slow = (c == 4);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input int n, input int s, input int m, input int a);
        exp_t e;
        e.niv = 3'(n);
        e.st  = 3'(s);
        e.mot = 1'(m);
        e.alm = 1'(a);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // monitor: one cycle after each window-end pulse, the decided outputs are compared
    initial begin
        logic  prev_v;
        exp_t  e;
        string n;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_v) begin
                check("venster_einde one cycle wide", int'(venster_einde), 0);
                if (q.size() == 0) begin
                    total = total + 1;
                    bad = bad + 1;
                    $display("FAIL window: unexpected window end at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    n = nq.pop_front();
                    check(n, int'({niveau, toestand, motor_aan, alarm}), int'(e));
                end
            end
            prev_v = venster_einde;
        end
    end

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic do_stop();
        @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
    endtask

    // Present one verdict for the next window and queue the expected outcome.
    task automatic verdict(input logic gd, input logic gl, input exp_t e, input string nm,
                           output int vcyc);
        bit found;
        gedaald = gd;
        gelijk  = gl;
        q.push_back(e);
        nq.push_back(nm);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (venster_einde) found = 1'b1;
        end
        vcyc = cyc;
        if (!found) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL %s: no window end within 200 cycles", nm);
            void'(q.pop_back());
            void'(nq.pop_back());
        end
        @(posedge clk);
        #1;
        gedaald = 1'b0;
        gelijk  = 1'b0;
    endtask

    initial begin
        int  v1, v2, v3, vx;
        bit  done;

        // reset values
        #2 reset = 1'b0;
        #1;
        check("reset niveau", int'(niveau), 0);
        check("reset motor_aan", int'(motor_aan), 0);
        check("reset toestand", int'(toestand), 0);
        check("reset alarm", int'(alarm), 0);
        check("reset venster_einde", int'(venster_einde), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // T2: unchanged stress holds level 2, windows every 20 clocks
        do_start();
        check("T2 start niveau", int'(niveau), 2);
        check("T2 start toestand", int'(toestand), 1);
        check("T2 start motor_aan", int'(motor_aan), 1);
        verdict(1'b0, 1'b1, mk(2, 1, 1, 0), "T2 gelijk 1", v1);
        verdict(1'b0, 1'b1, mk(2, 1, 1, 0), "T2 gelijk 2", v2);
        verdict(1'b0, 1'b1, mk(2, 1, 1, 0), "T2 gelijk 3", v3);
        check("T2 window period a", v2 - v1, 20);
        check("T2 window period b", v3 - v2, 20);
        do_stop();
        check("T2 stop toestand", int'(toestand), 0);

        // T1: asynchronous reset mid-session at level 5
        do_start();
        verdict(1'b0, 1'b0, mk(3, 1, 1, 0), "T1 rose 1", vx);
        verdict(1'b0, 1'b0, mk(4, 1, 1, 0), "T1 rose 2", vx);
        verdict(1'b0, 1'b0, mk(5, 1, 1, 0), "T1 rose 3", vx);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("T1 async reset niveau", int'(niveau), 0);
        check("T1 async reset motor_aan", int'(motor_aan), 0);
        check("T1 async reset toestand", int'(toestand), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // T3: rising stress saturates at 7, fourth rise at 7 raises alarm; gelijk holds attempts
        do_start();
        verdict(1'b0, 1'b0, mk(3, 1, 1, 0), "T3 rose to 3", vx);
        verdict(1'b0, 1'b0, mk(4, 1, 1, 0), "T3 rose to 4", vx);
        verdict(1'b0, 1'b0, mk(5, 1, 1, 0), "T3 rose to 5", vx);
        verdict(1'b0, 1'b0, mk(6, 1, 1, 0), "T3 rose to 6", vx);
        verdict(1'b0, 1'b0, mk(7, 1, 1, 0), "T3 rose to 7", vx);
        verdict(1'b0, 1'b0, mk(7, 1, 1, 0), "T3 rose at max 1", vx);
        verdict(1'b0, 1'b0, mk(7, 1, 1, 0), "T3 rose at max 2", vx);
        verdict(1'b0, 1'b1, mk(7, 1, 1, 0), "T3 gelijk at max", vx);
        verdict(1'b0, 1'b0, mk(7, 1, 1, 0), "T3 rose at max 3", vx);
        verdict(1'b0, 1'b0, mk(0, 4, 0, 1), "T3 rose at max 4 alarm", vx);
        repeat (30) @(posedge clk);
        #1;
        check("T3 alarm sticky", int'(alarm), 1);
        check("T3 alarm toestand", int'(toestand), 4);
        do_start();
        check("T3 start ignored in ALARM", int'(toestand), 4);

        // T6: stop clears alarm; stop beats start in RUST
        do_stop();
        check("T6 stop clears alarm", int'(alarm), 0);
        check("T6 stop toestand", int'(toestand), 0);
        @(posedge clk);
        #1 start = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        stop = 1'b0;
        check("T6 start+stop toestand", int'(toestand), 0);
        check("T6 start+stop motor_aan", int'(motor_aan), 0);

        // T4: falling stress down to 0, then wind-down for one window
        do_start();
        verdict(1'b1, 1'b0, mk(1, 1, 1, 0), "T4 gedaald to 1", vx);
        verdict(1'b1, 1'b0, mk(0, 1, 1, 0), "T4 gedaald to 0", vx);
        verdict(1'b1, 1'b0, mk(0, 3, 1, 0), "T4 gedaald at 0 afbouw", vx);
        repeat (8) @(posedge clk);
        #1;
        check("T4 still afbouw", int'(toestand), 3);
        do_start();
        check("T4 start ignored in AFBOUW", int'(toestand), 3);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (toestand == 3'd0) done = 1'b1;
        end
        check("T4 afbouw ends in RUST", int'(done), 1);
        check("T4 motor off after afbouw", int'(motor_aan), 0);

        // T5: gedaald wins over gelijk
        do_start();
        verdict(1'b0, 1'b0, mk(3, 1, 1, 0), "T5 rose to 3", vx);
        verdict(1'b1, 1'b1, mk(2, 1, 1, 0), "T5 gedaald+gelijk", vx);
        do_stop();

        repeat (5) @(posedge clk);
        check("scoreboard drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
